uplink_arbiter: RTL and testbench

UPLINK_ARBITER -- requirements
Module: uplink_arbiter

---
 rtl/uplink_pkg.sv | 34 +++
 rtl/crc16_modbus_byte.sv | 20 ++
 rtl/uplink_arbiter.sv | 177 +++++++++++++++++
 tb/tb_uplink_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uplink_pkg.sv
// Shared constants and state encoding for the uplink arbiter.
// The CRC states exist only when UPLINK_CRC_EN is defined.
package uplink_pkg;

   localparam logic [15:0] CRC_POLY = 16'hA001;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_LEN,
      ST_CHN,
      ST_RD,
      ST_DATA
`ifdef UPLINK_CRC_EN
      ,
      ST_CRC_LO,
      ST_CRC_HI
`endif
   } state_t;

   // Frame sync word "$CTF", sent before every frame.
   function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = 8'h24;
         2'd1:    b = 8'h43;
         2'd2:    b = 8'h54;
         default: b = 8'h46;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/crc16_modbus_byte.sv
// One-byte CRC-16/MODBUS update (reflected polynomial), purely combinational.
module crc16_modbus_byte
   import uplink_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  byte_in,
   output logic [15:0] crc_out
);

   logic [15:0] c;

   always_comb begin
      c = crc_in ^ {8'h00, byte_in};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/uplink_arbiter.sv
// Round-robin arbiter that frames channel FIFO contents onto one UART byte stream.
// Define UPLINK_CRC_EN to append a CRC-16/MODBUS trailer to every frame.
module uplink_arbiter
   import uplink_pkg::*;
#(
   parameter int N_CH    = 20,
   parameter int MAX_LEN = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_CH-1:0]     ch_empty,
   input  logic [8*N_CH-1:0]   ch_usedw,
   input  logic [8*N_CH-1:0]   ch_q,
   output logic [N_CH-1:0]     ch_rdreq,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                busy
);

   localparam int              GW        = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [GW-1:0]   LAST_CH   = GW'(N_CH - 1);
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
`ifdef UPLINK_CRC_EN
   localparam state_t          FRAME_END = ST_CRC_LO;
`else
   localparam state_t          FRAME_END = ST_IDLE;
`endif

   state_t          state, state_nxt;
   logic [GW-1:0]   grant;
   logic [GW-1:0]   rr_pick, rr_idx;
   logic            rr_found;
   logic [7:0]      len, len_snap, byte_cnt;
   logic [1:0]      hdr_idx;
   logic [7:0]      data_hold;
   logic            data_held;
   logic            accept;
   logic [7:0]      usedw_arr [N_CH];
   logic [7:0]      q_arr     [N_CH];

   for (genvar i = 0; i < N_CH; i++) begin : g_split
      assign usedw_arr[i] = ch_usedw[8*i +: 8];
      assign q_arr[i]     = ch_q[8*i +: 8];
   end

   assign accept = tx_valid && tx_ready;
   assign busy   = (state != ST_IDLE);

   // Search starts just after the previous winner, so every channel gets a turn.
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = grant;
      rr_idx   = '0;
      for (int k = 1; k <= N_CH; k++) begin
         rr_idx = GW'((int'(grant) + k) % N_CH);
         if (!rr_found && !ch_empty[rr_idx]) begin
            rr_found = 1'b1;
            rr_pick  = rr_idx;
         end
      end
   end

   assign len_snap = (usedw_arr[rr_pick] > MAX_LEN_B) ? MAX_LEN_B : usedw_arr[rr_pick];

`ifdef UPLINK_CRC_EN
   logic [15:0] crc, crc_nxt;

   crc16_modbus_byte u_crc (
      .crc_in  (crc),
      .byte_in (tx_data),
      .crc_out (crc_nxt)
   );

   // The header is excluded; LEN, CHN and payload feed the CRC as they are accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= CRC_INIT;
      end else if (state == ST_IDLE && rr_found) begin
         crc <= CRC_INIT;
      end else if (accept && (state == ST_LEN || state == ST_CHN || state == ST_DATA)) begin
         crc <= crc_nxt;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      ch_rdreq  = '0;
      unique case (state)
         ST_IDLE: begin
            if (rr_found) state_nxt = ST_HDR;
         end
         ST_HDR: begin
            tx_valid = 1'b1;
            tx_data  = hdr_byte(hdr_idx);
            if (tx_ready && hdr_idx == 2'd3) state_nxt = ST_LEN;
         end
         ST_LEN: begin
            tx_valid = 1'b1;
            tx_data  = len;
            if (tx_ready) state_nxt = ST_CHN;
         end
         ST_CHN: begin
            tx_valid = 1'b1;
            tx_data  = 8'(grant) + 8'd1;
            if (tx_ready) state_nxt = (len == 8'd0) ? FRAME_END : ST_RD;
         end
         ST_RD: begin
            ch_rdreq[grant] = 1'b1;
            state_nxt       = ST_DATA;
         end
         ST_DATA: begin
            tx_valid = 1'b1;
            tx_data  = data_held ? data_hold : q_arr[grant];
            if (tx_ready) state_nxt = (byte_cnt + 8'd1 == len) ? FRAME_END : ST_RD;
         end
`ifdef UPLINK_CRC_EN
         ST_CRC_LO: begin
            tx_valid = 1'b1;
            tx_data  = crc[7:0];
            if (tx_ready) state_nxt = ST_CRC_HI;
         end
         ST_CRC_HI: begin
            tx_valid = 1'b1;
            tx_data  = crc[15:8];
            if (tx_ready) state_nxt = ST_IDLE;
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A stalled payload byte is captured so tx_data stays put even if the FIFO output moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         grant     <= LAST_CH;
         len       <= 8'd0;
         byte_cnt  <= 8'd0;
         hdr_idx   <= 2'd0;
         data_hold <= 8'h00;
         data_held <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (rr_found) begin
                  grant    <= rr_pick;
                  len      <= len_snap;
                  byte_cnt <= 8'd0;
                  hdr_idx  <= 2'd0;
               end
            end
            ST_HDR: begin
               if (accept) hdr_idx <= hdr_idx + 2'd1;
            end
            ST_RD: begin
               data_held <= 1'b0;
            end
            ST_DATA: begin
               if (accept) begin
                  byte_cnt  <= byte_cnt + 8'd1;
                  data_held <= 1'b0;
               end else if (!data_held) begin
                  data_hold <= q_arr[grant];
                  data_held <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uplink_arbiter.sv
// Self-checking bench for uplink_arbiter: FIFO models, a frame-level reference model and directed tests.
// Works with or without UPLINK_CRC_EN defined.
`timescale 1ns/1ps
module tb_uplink_arbiter;

   localparam int N_CH    = 20;
   localparam int MAX_LEN = 64;
`ifdef UPLINK_CRC_EN
   localparam int OVH = 8;
`else
   localparam int OVH = 6;
`endif

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N_CH-1:0]     ch_empty;
   logic [8*N_CH-1:0]   ch_usedw;
   logic [8*N_CH-1:0]   ch_q;
   logic [N_CH-1:0]     ch_rdreq;
   logic [7:0]          tx_data;
   logic                tx_valid;
   logic                tx_ready;
   logic                busy;

   int           checks = 0;
   int           passed = 0;
   logic [7:0]   fifo [N_CH][$];
   logic [7:0]   exp_q[$];
   logic [7:0]   got_q[$];
   int           model_last = N_CH - 1;
   int           rd_count [N_CH];
   logic         ready_random = 1'b0;

   uplink_arbiter #(.N_CH(N_CH), .MAX_LEN(MAX_LEN)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ch_empty (ch_empty),
      .ch_usedw (ch_usedw),
      .ch_q     (ch_q),
      .ch_rdreq (ch_rdreq),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
   endtask

   function automatic logic [15:0] crc_model(input logic [7:0] data[$]);
      logic [15:0] c = 16'hFFFF;
      foreach (data[i]) begin
         c = c ^ {8'h00, data[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   task automatic refresh_flags();
      for (int i = 0; i < N_CH; i++) begin
         ch_empty[i]       = (fifo[i].size() == 0);
         ch_usedw[8*i +: 8] = (fifo[i].size() > 255) ? 8'hFF : 8'(fifo[i].size());
      end
   endtask

   // Expected frame for the next grant, derived from FIFO contents before any payload read.
   task automatic build_frame();
      int ch = -1;
      int len;
      logic [7:0] body[$];
      logic [15:0] c;
      for (int k = 1; k <= N_CH; k++) begin
         int idx = (model_last + k) % N_CH;
         if (ch < 0 && fifo[idx].size() > 0) ch = idx;
      end
      if (ch < 0) return;
      model_last = ch;
      len = (fifo[ch].size() < MAX_LEN) ? fifo[ch].size() : MAX_LEN;
      exp_q = '{8'h24, 8'h43, 8'h54, 8'h46};
      body.push_back(8'(len));
      body.push_back(8'(ch + 1));
      for (int j = 0; j < len; j++) body.push_back(fifo[ch][j]);
      foreach (body[i]) exp_q.push_back(body[i]);
      c = crc_model(body);
`ifdef UPLINK_CRC_EN
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
`endif
   endtask

   // Source FIFO model: rdreq seen late in a cycle returns data just after the next edge.
   initial begin
      logic [N_CH-1:0] rd;
      ch_q = '0;
      foreach (rd_count[i]) rd_count[i] = 0;
      refresh_flags();
      forever begin
         @(negedge clk);
         #4 rd = ch_rdreq;
         @(posedge clk);
         #1;
         for (int i = 0; i < N_CH; i++) begin
            if (rd[i]) begin
               rd_count[i]++;
               if (fifo[i].size() > 0) ch_q[8*i +: 8] = fifo[i].pop_front();
            end
         end
         refresh_flags();
      end
   end

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 tx_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Per-cycle compare against the frame model plus stall stability.
   initial begin
      logic [7:0] prev_data = 8'h00;
      logic       prev_stall = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            model_last = N_CH - 1;
            prev_stall = 1'b0;
         end else begin
            checkOutput("rdreq_onehot0", int'($onehot0(ch_rdreq)), 1);
            if (prev_stall) begin
               checkOutput("stall_valid", int'(tx_valid), 1);
               checkOutput("stall_data", int'(tx_data), int'(prev_data));
            end
            if (tx_valid) checkOutput("busy_during_valid", int'(busy), 1);
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) build_frame();
               if (exp_q.size() == 0) checkOutput("unexpected_byte", int'(tx_data), -1);
               else checkOutput("frame_byte", int'(tx_data), int'(exp_q.pop_front()));
               got_q.push_back(tx_data);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
         end
      end
   end

   task automatic applyStimulus(input int ch, input int n, input int base);
      @(negedge clk);
      for (int j = 0; j < n; j++) fifo[ch].push_back(8'(base + j));
      refresh_flags();
   endtask

   task automatic wait_done(input string name, input int max_cycles);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(!busy && !tx_valid && ch_empty == '1) && n < max_cycles);
      if (n >= max_cycles) checkOutput({name, "_timeout"}, n, 0);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      #12;
      checkOutput("reset_tx_valid", int'(tx_valid), 0);
      checkOutput("reset_tx_data", int'(tx_data), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_rdreq", int'(ch_rdreq), 0);
      begin
         logic [7:0] v[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
         checkOutput("model_crc_check", int'(crc_model(v)), 16'h4B37);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Two bytes on channel 2
      got_q.delete();
      foreach (rd_count[i]) rd_count[i] = 0;
      @(negedge clk);
      fifo[2].push_back(8'h11);
      fifo[2].push_back(8'h22);
      refresh_flags();
      wait_done("ch2", 200);
      checkOutput("ch2_frame_len", got_q.size(), OVH + 2);
      checkOutput("ch2_len_byte", int'(got_q[4]), 2);
      checkOutput("ch2_chn_byte", int'(got_q[5]), 3);
      checkOutput("ch2_payload0", int'(got_q[6]), 8'h11);
      checkOutput("ch2_payload1", int'(got_q[7]), 8'h22);
      checkOutput("ch2_rdreq_pulses", rd_count[2], 2);

      // Round robin: 0 then 5, then refill 0/5/7 continues after 5
      reset_dut();
      got_q.delete();
      applyStimulus(0, 1, 8'hA0);
      fifo[5].push_back(8'hA5);
      refresh_flags();
      wait_done("rr1", 200);
      checkOutput("rr1_first_chn", int'(got_q[5]), 1);
      checkOutput("rr1_second_chn", int'(got_q[OVH + 1 + 5]), 6);
      got_q.delete();
      applyStimulus(0, 1, 8'hB0);
      fifo[5].push_back(8'hB5);
      fifo[7].push_back(8'hB7);
      refresh_flags();
      wait_done("rr2", 300);
      checkOutput("rr2_first_chn", int'(got_q[5]), 8);
      checkOutput("rr2_second_chn", int'(got_q[OVH + 1 + 5]), 1);
      checkOutput("rr2_third_chn", int'(got_q[2 * (OVH + 1) + 5]), 6);

      // Length cap: 200 bytes queued, 64 per frame
      got_q.delete();
      foreach (rd_count[i]) rd_count[i] = 0;
      applyStimulus(9, 200, 0);
      n = 0;
      while (!busy && n < 20) begin @(negedge clk); n++; end
      checkOutput("cap_grant_seen", int'(busy), 1);
      n = 0;
      while (busy && n < 400) begin @(negedge clk); n++; end
      checkOutput("cap_len_byte", int'(got_q[4]), 8'h40);
      checkOutput("cap_rdreq_pulses", rd_count[9], 64);
      checkOutput("cap_left_in_fifo", int'(ch_usedw[8*9 +: 8]), 136);
      wait_done("cap_drain", 2000);

      // Random back-pressure over two channels
      got_q.delete();
      ready_random = 1'b1;
      applyStimulus(3, 5, 8'h50);
      applyStimulus(4, 3, 8'h60);
      wait_done("stall", 1000);
      ready_random = 1'b0;
      checkOutput("stall_total_bytes", got_q.size(), 2 * OVH + 8);

      // Reset in the middle of a payload
      foreach (rd_count[i]) rd_count[i] = 0;
      applyStimulus(1, 10, 8'h70);
      n = 0;
      while (rd_count[1] < 3 && n < 200) begin @(negedge clk); n++; end
      checkOutput("midrst_reached_payload", int'(rd_count[1] >= 3), 1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midrst_tx_valid", int'(tx_valid), 0);
      checkOutput("midrst_tx_data", int'(tx_data), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_rdreq", int'(ch_rdreq), 0);
      @(negedge clk);
      @(negedge clk);
      got_q.delete();
      rst_n = 1'b1;
      wait_done("midrst_after", 300);
      checkOutput("midrst_first_byte", int'(got_q[0]), 8'h24);
      checkOutput("midrst_len_byte", int'(got_q[4]), 7);
      checkOutput("midrst_chn_byte", int'(got_q[5]), 2);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
